uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 143 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// The baud counter paces every bit; tx is registered so the pin never glitches.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     baud_cnt, baud_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
    logic                 parity_bit, parity_bit_n;
    logic                 tx_n;
    logic                 tx_done_n;
    logic                 bit_end;

    // Handshake: tx_start is a request taken only while tx_busy is low (IDLE,
    // including the tx_done cycle); requests seen while tx_busy is high are dropped.
    assign tx_busy   = (state != S_IDLE);
    assign dbg_state = state;
    assign bit_end   = (baud_cnt == CNT_LAST);

    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt;
        bit_idx_n    = bit_idx;
        shift_reg_n  = shift_reg;
        parity_bit_n = parity_bit;
        tx_done_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    shift_reg_n  = tx_data;
                    parity_bit_n = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
                    baud_cnt_n   = '0;
                    bit_idx_n    = '0;
                    state_n      = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = S_DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_n  = '0;
                    shift_reg_n = {1'b0, shift_reg[DATA_BITS-1:1]};
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = S_STOP;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_n = '0;
                        tx_done_n = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Line level follows the state being entered, so tx lines up with the state register.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_reg_n[0];
            S_PARITY: tx_n = parity_bit_n;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            shift_reg  <= shift_reg_n;
            parity_bit <= parity_bit_n;
            tx         <= tx_n;
            tx_done    <= tx_done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT = 4 across parity and stop-bit variants.
// Instance 0: no parity/1 stop, 1: odd parity, 2: even parity, 3: no parity/2 stop.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a [4];
    logic [7:0] data_a  [4];
    logic       tx_a    [4];
    logic       busy_a  [4];
    logic       done_a  [4];
    logic [2:0] st_a    [4];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_none (
        .clk(clk), .reset(reset), .tx_start(start_a[0]), .tx_data(data_a[0]),
        .tx_busy(busy_a[0]), .tx_done(done_a[0]), .tx(tx_a[0]), .dbg_state(st_a[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .reset(reset), .tx_start(start_a[1]), .tx_data(data_a[1]),
        .tx_busy(busy_a[1]), .tx_done(done_a[1]), .tx(tx_a[1]), .dbg_state(st_a[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_even (
        .clk(clk), .reset(reset), .tx_start(start_a[2]), .tx_data(data_a[2]),
        .tx_busy(busy_a[2]), .tx_done(done_a[2]), .tx(tx_a[2]), .dbg_state(st_a[2]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
        .clk(clk), .reset(reset), .tx_start(start_a[3]), .tx_data(data_a[3]),
        .tx_busy(busy_a[3]), .tx_done(done_a[3]), .tx(tx_a[3]), .dbg_state(st_a[3]));

    // Captures one frame on instance sel, one sample per negedge, starting the cycle after acceptance.
    // bits[i] is frame bit i (start = bit 0); stable drops if any bit wobbles within its CPB cycles.
    task automatic run_frame(input int sel, input bit drive, input logic [7:0] d,
                             input logic [7:0] d2, input bit hold, input int pulse_at,
                             input int nbits, output logic [15:0] bits, output bit stable,
                             output int busy_cnt, output int done_at, output int done_cnt,
                             output int post_low);
        int len;
        int b;
        bits = '0; stable = 1'b1; busy_cnt = 0; done_at = 0; done_cnt = 0; post_low = 0;
        len = hold ? nbits * CPB + 1 : nbits * CPB + 4;
        if (drive) begin
            start_a[sel] = 1'b1;
            data_a[sel]  = d;
        end
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == 1 && drive) data_a[sel] = d2;
            if (c == 1 && !hold) start_a[sel] = 1'b0;
            b = (c - 1) / CPB;
            if (b < nbits) begin
                if ((c - 1) % CPB == 0) bits[b] = tx_a[sel];
                else if (tx_a[sel] !== bits[b]) stable = 1'b0;
            end
            if (busy_a[sel] === 1'b1) busy_cnt++;
            if (done_a[sel] === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (done_at != 0 && c >= done_at && tx_a[sel] !== 1'b1) post_low++;
            if (pulse_at != 0 && c == pulse_at) begin
                start_a[sel] = 1'b1;
                data_a[sel]  = 8'hFF;
            end
            if (pulse_at != 0 && c == pulse_at + 1) start_a[sel] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (tx_a[0] !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx_a[0]); else n_pass++;
        n_total++; if (busy_a[0] !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a[0]); else n_pass++;
        n_total++; if (done_a[0] !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_a[0]); else n_pass++;
        n_total++; if (st_a[0] !== 3'd0) $display("FAIL reset_state: got %0d expected 0", st_a[0]); else n_pass++;
        n_total++; if (tx_a[3] !== 1'b1) $display("FAIL reset_tx_stop2: got %b expected 1", tx_a[3]); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [15:0] bits; bit stable; int busy_cnt, done_at, done_cnt, post_low;
        run_frame(0, 1'b1, 8'h55, 8'hAA, 1'b0, 0, 10, bits, stable, busy_cnt, done_at, done_cnt, post_low);
        n_total++; if (bits[9:0] !== 10'h2AA) $display("FAIL basic_bits: got %h expected 2aa", bits[9:0]); else n_pass++;
        n_total++; if (!stable) $display("FAIL basic_stable: got 0 expected 1"); else n_pass++;
        n_total++; if (busy_cnt != 40) $display("FAIL basic_busy_len: got %0d expected 40", busy_cnt); else n_pass++;
        n_total++; if (done_at != 41) $display("FAIL basic_done_at: got %0d expected 41", done_at); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); else n_pass++;
        n_total++; if (post_low != 0) $display("FAIL basic_idle_high: got %0d low samples expected 0", post_low); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits; bit stable; int busy_cnt, done_at, done_cnt, post_low;
        run_frame(0, 1'b1, 8'hA3, 8'h0F, 1'b1, 0, 10, bits, stable, busy_cnt, done_at, done_cnt, post_low);
        n_total++; if (bits[9:0] !== 10'h346) $display("FAIL b2b_first_bits: got %h expected 346", bits[9:0]); else n_pass++;
        n_total++; if (done_at != 41) $display("FAIL b2b_first_done_at: got %0d expected 41", done_at); else n_pass++;
        n_total++; if (busy_a[0] !== 1'b0) $display("FAIL b2b_done_busy: got %b expected 0", busy_a[0]); else n_pass++;
        run_frame(0, 1'b0, 8'h00, 8'h00, 1'b0, 0, 10, bits, stable, busy_cnt, done_at, done_cnt, post_low);
        n_total++; if (bits[9:0] !== 10'h21E) $display("FAIL b2b_second_bits: got %h expected 21e", bits[9:0]); else n_pass++;
        n_total++; if (!stable) $display("FAIL b2b_second_stable: got 0 expected 1"); else n_pass++;
        n_total++; if (done_at != 41) $display("FAIL b2b_second_done_at: got %0d expected 41", done_at); else n_pass++;
    endtask

    task automatic test_ignore_busy_start();
        logic [15:0] bits; bit stable; int busy_cnt, done_at, done_cnt, post_low;
        run_frame(0, 1'b1, 8'h12, 8'h34, 1'b0, 20, 10, bits, stable, busy_cnt, done_at, done_cnt, post_low);
        n_total++; if (bits[9:0] !== 10'h224) $display("FAIL ignore_bits: got %h expected 224", bits[9:0]); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL ignore_done_cnt: got %0d expected 1", done_cnt); else n_pass++;
        n_total++; if (post_low != 0) $display("FAIL ignore_no_requeue: got %0d low samples expected 0", post_low); else n_pass++;
    endtask

    task automatic test_parity();
        logic [15:0] bits; bit stable; int busy_cnt, done_at, done_cnt, post_low;
        run_frame(2, 1'b1, 8'h07, 8'h00, 1'b0, 0, 11, bits, stable, busy_cnt, done_at, done_cnt, post_low);
        n_total++; if (bits[10:0] !== 11'h60E) $display("FAIL even_bits: got %h expected 60e", bits[10:0]); else n_pass++;
        n_total++; if (busy_cnt != 44) $display("FAIL even_busy_len: got %0d expected 44", busy_cnt); else n_pass++;
        n_total++; if (done_at != 45) $display("FAIL even_done_at: got %0d expected 45", done_at); else n_pass++;
        run_frame(1, 1'b1, 8'h07, 8'hFF, 1'b0, 0, 11, bits, stable, busy_cnt, done_at, done_cnt, post_low);
        n_total++; if (bits[10:0] !== 11'h40E) $display("FAIL odd_bits: got %h expected 40e", bits[10:0]); else n_pass++;
        n_total++; if (!stable) $display("FAIL odd_stable: got 0 expected 1"); else n_pass++;
        n_total++; if (done_at != 45) $display("FAIL odd_done_at: got %0d expected 45", done_at); else n_pass++;
    endtask

    task automatic test_two_stop_bits();
        logic [15:0] bits; bit stable; int busy_cnt, done_at, done_cnt, post_low;
        run_frame(3, 1'b1, 8'h80, 8'h01, 1'b0, 0, 11, bits, stable, busy_cnt, done_at, done_cnt, post_low);
        n_total++; if (bits[10:0] !== 11'h700) $display("FAIL stop2_bits: got %h expected 700", bits[10:0]); else n_pass++;
        n_total++; if (busy_cnt != 44) $display("FAIL stop2_busy_len: got %0d expected 44", busy_cnt); else n_pass++;
        n_total++; if (done_at != 45) $display("FAIL stop2_done_at: got %0d expected 45", done_at); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL stop2_done_cnt: got %0d expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits; bit stable; int busy_cnt, done_at, done_cnt, post_low;
        int bad_done;
        start_a[0] = 1'b1; data_a[0] = 8'h5A;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (17) @(negedge clk);
        // Cycle 18 of the frame sits inside data bit 3, which is 1 for 0x5A.
        n_total++; if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b1)
            $display("FAIL midrst_pre: got tx=%b busy=%b expected tx=1 busy=1", tx_a[0], busy_a[0]); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++; if (tx_a[0] !== 1'b1) $display("FAIL midrst_tx: got %b expected 1", tx_a[0]); else n_pass++;
        n_total++; if (busy_a[0] !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_a[0]); else n_pass++;
        n_total++; if (done_a[0] !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done_a[0]); else n_pass++;
        bad_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || tx_a[0] !== 1'b1) bad_done++;
        end
        n_total++; if (bad_done != 0) $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad_done); else n_pass++;
        run_frame(0, 1'b1, 8'h3C, 8'hC3, 1'b0, 0, 10, bits, stable, busy_cnt, done_at, done_cnt, post_low);
        n_total++; if (bits[9:0] !== 10'h278) $display("FAIL midrst_next_bits: got %h expected 278", bits[9:0]); else n_pass++;
        n_total++; if (done_at != 41) $display("FAIL midrst_next_done_at: got %0d expected 41", done_at); else n_pass++;
    endtask

    task automatic test_reset_with_start();
        reset = 1'b1; start_a[0] = 1'b1; data_a[0] = 8'h81;
        @(negedge clk);
        reset = 1'b0; start_a[0] = 1'b0;
        n_total++; if (busy_a[0] !== 1'b0 || tx_a[0] !== 1'b1)
            $display("FAIL rststart_now: got busy=%b tx=%b expected busy=0 tx=1", busy_a[0], tx_a[0]); else n_pass++;
        @(negedge clk);
        n_total++; if (busy_a[0] !== 1'b0 || tx_a[0] !== 1'b1)
            $display("FAIL rststart_dropped: got busy=%b tx=%b expected busy=0 tx=1", busy_a[0], tx_a[0]); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_a[i] = 1'b0;
            data_a[i]  = 8'h00;
        end
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_ignore_busy_start();
        test_parity();
        test_two_stop_bits();
        test_reset_mid_frame();
        test_reset_with_start();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
